// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse keying stage.
//   - Element/gap durations in Morse units.
//   - Character code values (0..25 letters, 26 word space, 27..31 invalid).
//   - Keyer FSM state encoding.
//   - elem_units(): unit count for a single element from its pattern bit.
package morse_pkg;

  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
  localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;

  localparam logic [4:0] CODE_SPACE      = 5'd26;
  localparam logic [4:0] CODE_MAX_LETTER = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_GAP   = 2'd3
  } morse_state_e;

  // Pattern bit 1 = dash, 0 = dot.
  function automatic logic [2:0] elem_units(input logic is_dash);
    return is_dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational letter lookup.
//   code    [4:0] : character code, 0..25 = A..Z
//   len     [2:0] : number of elements (1..4); 0 for codes 26..31
//   pattern [3:0] : elements left-aligned, pattern[3] is sent first,
//                   1 = dash, 0 = dot; unused low bits are 0
module morse_rom (
  input  logic [4:0] code,
  output logic [2:0] len,
  output logic [3:0] pattern
);

  always_comb begin
    len     = 3'd0;
    pattern = 4'b0000;
    case (code)
      5'd0:  begin len = 3'd2; pattern = 4'b0100; end // A .-
      5'd1:  begin len = 3'd4; pattern = 4'b1000; end // B -...
      5'd2:  begin len = 3'd4; pattern = 4'b1010; end // C -.-.
      5'd3:  begin len = 3'd3; pattern = 4'b1000; end // D -..
      5'd4:  begin len = 3'd1; pattern = 4'b0000; end // E .
      5'd5:  begin len = 3'd4; pattern = 4'b0010; end // F ..-.
      5'd6:  begin len = 3'd3; pattern = 4'b1100; end // G --.
      5'd7:  begin len = 3'd4; pattern = 4'b0000; end // H ....
      5'd8:  begin len = 3'd2; pattern = 4'b0000; end // I ..
      5'd9:  begin len = 3'd4; pattern = 4'b0111; end // J .---
      5'd10: begin len = 3'd3; pattern = 4'b1010; end // K -.-
      5'd11: begin len = 3'd4; pattern = 4'b0100; end // L .-..
      5'd12: begin len = 3'd2; pattern = 4'b1100; end // M --
      5'd13: begin len = 3'd2; pattern = 4'b1000; end // N -.
      5'd14: begin len = 3'd3; pattern = 4'b1110; end // O ---
      5'd15: begin len = 3'd4; pattern = 4'b0110; end // P .--.
      5'd16: begin len = 3'd4; pattern = 4'b1101; end // Q --.-
      5'd17: begin len = 3'd3; pattern = 4'b0100; end // R .-.
      5'd18: begin len = 3'd3; pattern = 4'b0000; end // S ...
      5'd19: begin len = 3'd1; pattern = 4'b1000; end // T -
      5'd20: begin len = 3'd3; pattern = 4'b0010; end // U ..-
      5'd21: begin len = 3'd4; pattern = 4'b0001; end // V ...-
      5'd22: begin len = 3'd3; pattern = 4'b0110; end // W .--
      5'd23: begin len = 3'd4; pattern = 4'b1001; end // X -..-
      5'd24: begin len = 3'd4; pattern = 4'b1011; end // Y -.--
      5'd25: begin len = 3'd4; pattern = 4'b1100; end // Z --..
      default: begin len = 3'd0; pattern = 4'b0000; end
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: turns one character code per handshake into Morse keying on w.
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high
//   char_valid : upstream presents a character on char_code
//   char_code  : 0..25 = A..Z, 26 = word space, 27..31 = invalid (dropped)
//   char_ready : high exactly while the FSM is IDLE
//   w          : registered keying line, 1 = mark
//   busy       : inverse of char_ready
//   dbg_state  : current FSM state, for observation only
//
// Handshake: a character transfers on a rising edge where char_valid and
// char_ready are both high; char_code is sampled only on that edge. The
// producer may hold char_valid high and the next transfer happens on the
// first edge where the keyer is IDLE again. Reset overrides any transfer.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         char_valid,
  input  logic [4:0]   char_code,
  output logic         char_ready,
  output logic         w,
  output logic         busy,
  output morse_state_e dbg_state
);

  localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  morse_state_e     state_q, state_d;
  logic [3:0]       pat_q, pat_d;
  logic [2:0]       len_q, len_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       unit_q, unit_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  logic [2:0] rom_len;
  logic [3:0] rom_pat;
  logic       unit_end;
  logic       expired;
  logic [1:0] next_idx;

  morse_rom u_rom (
    .code    (char_code),
    .len     (rom_len),
    .pattern (rom_pat)
  );

  assign unit_end = (cyc_q == CYC_LAST);
  // A zero-unit load (invalid code) expires on its first cycle, which gives
  // the one-cycle busy pulse for dropped codes.
  assign expired  = (unit_q == 3'd0) || ((unit_q == 3'd1) && unit_end);
  assign next_idx = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cyc_d   = unit_end ? '0 : cyc_q + 1'b1;
    unit_d  = (unit_end && unit_q != 3'd0) ? unit_q - 3'd1 : unit_q;

    case (state_q)
      ST_IDLE: begin
        cyc_d  = '0;
        unit_d = 3'd0;
        idx_d  = 2'd0;
        if (char_valid) begin
          if (char_code <= CODE_MAX_LETTER) begin
            state_d = ST_MARK;
            pat_d   = rom_pat;
            len_d   = rom_len;
            unit_d  = elem_units(rom_pat[3]);
          end else if (char_code == CODE_SPACE) begin
            state_d = ST_GAP;
            unit_d  = WORD_GAP_UNITS;
          end else begin
            state_d = ST_GAP;
            unit_d  = 3'd0;
          end
        end
      end

      ST_MARK: begin
        if (expired) begin
          cyc_d = '0;
          // More elements remain while idx < len-1.
          if ({1'b0, idx_q} < (len_q - 3'd1)) begin
            state_d = ST_SPACE;
            unit_d  = ELEM_GAP_UNITS;
          end else begin
            state_d = ST_GAP;
            unit_d  = LETTER_GAP_UNITS;
          end
        end
      end

      ST_SPACE: begin
        if (expired) begin
          cyc_d   = '0;
          idx_d   = next_idx;
          state_d = ST_MARK;
          // Pattern is left-aligned: element i lives at bit 3-i.
          unit_d  = elem_units(pat_q[2'd3 - next_idx]);
        end
      end

      ST_GAP: begin
        if (expired) begin
          state_d = ST_IDLE;
          cyc_d   = '0;
          unit_d  = 3'd0;
          idx_d   = 2'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        unit_d  = 3'd0;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= 4'b0000;
      len_q   <= 3'd0;
      idx_q   <= 2'd0;
      unit_q  <= 3'd0;
      cyc_q   <= '0;
      w       <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      unit_q  <= unit_d;
      cyc_q   <= cyc_d;
      // Registered from the next state so w lines up with the MARK state.
      w       <= (state_d == ST_MARK);
    end
  end

  assign char_ready = (state_q == ST_IDLE);
  assign busy       = ~char_ready;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: three keyers (UNIT_CYCLES = 1, 2, 4) driven from one clock
// and checked every cycle against a waveform model built from Morse strings.
module tb_morse_keyer;
  import morse_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  logic         valid_v [3];
  logic [4:0]   code_v  [3];
  logic         rdy     [3];
  logic         w_v     [3];
  logic         busy_v  [3];
  morse_state_e st      [3];

  int unit_of [3] = '{1, 2, 4};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    morse_keyer #(.UNIT_CYCLES(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk        (clk),
      .reset      (reset),
      .char_valid (valid_v[g]),
      .char_code  (code_v[g]),
      .char_ready (rdy[g]),
      .w          (w_v[g]),
      .busy       (busy_v[g]),
      .dbg_state  (st[g])
    );
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  // Future w values, one per cycle the keyer is busy; empty means idle.
  logic [0:0] exp_q [3][$];

  string morse_tab [26] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--.."};

  task automatic check(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (unit=%0d) got %0h expected %0h at %0t", name, unit_of[i], act, exp, $time);
    end
  endtask

  // Expand one accepted character into its per-cycle w values.
  function automatic void expand(input int i, input logic [4:0] c);
    string s;
    int u;
    int units;
    u = unit_of[i];
    if (c <= 5'd25) begin
      s = morse_tab[c];
      for (int j = 0; j < s.len(); j++) begin
        units = (s[j] == "-") ? 3 : 1;
        for (int r = 0; r < units * u; r++) exp_q[i].push_back(1'b1);
        if (j < s.len() - 1)
          for (int r = 0; r < u; r++) exp_q[i].push_back(1'b0);
      end
      for (int r = 0; r < 3 * u; r++) exp_q[i].push_back(1'b0);
    end else if (c == 5'd26) begin
      for (int r = 0; r < 7 * u; r++) exp_q[i].push_back(1'b0);
    end else begin
      exp_q[i].push_back(1'b0);
    end
  endfunction

  // Compare process: at each falling edge the outputs reflect the last
  // rising edge; then predict whether the next rising edge accepts.
  always @(negedge clk) begin
    logic e_w;
    logic e_busy;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        exp_q[i].delete();
        e_w    = 1'b0;
        e_busy = 1'b0;
      end else if (exp_q[i].size() > 0) begin
        e_w    = exp_q[i].pop_front();
        e_busy = 1'b1;
      end else begin
        e_w    = 1'b0;
        e_busy = 1'b0;
      end
      check("w", i, 64'(w_v[i]), 64'(e_w));
      check("char_ready", i, 64'(rdy[i]), 64'(!e_busy));
      check("busy", i, 64'(busy_v[i]), 64'(e_busy));
      check("state_idle", i, 64'(st[i] == ST_IDLE), 64'(!e_busy));
      if (!reset && !e_busy && valid_v[i]) expand(i, code_v[i]);
    end
  end

  // ---------------- driver tasks ----------------
  // Presents c on instance i and returns 1ns after the accepting edge.
  task automatic send(input int i, input logic [4:0] c, input bit hold);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    valid_v[i] = 1'b1;
    code_v[i]  = c;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = rdy[i];
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout (unit=%0d) code %0d never accepted", unit_of[i], c);
      valid_v[i] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) begin
        valid_v[i] = 1'b0;
        code_v[i]  = 5'($urandom);
      end
    end
  endtask

  // Records w each cycle until char_ready returns; wv holds the first
  // sample in its highest used bit, blen is the busy length.
  task automatic capture(input int i, output logic [63:0] wv, output int blen);
    bit done;
    done = 1'b0;
    wv   = '0;
    blen = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (rdy[i]) done = 1'b1;
      else begin
        wv = {wv[62:0], w_v[i]};
        blen++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout (unit=%0d)", unit_of[i]);
    end
  endtask

  task automatic rand_run(input int i);
    logic [4:0] c;
    bit hold;
    for (int k = 0; k < 25; k++) begin
      c = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
      hold = ($urandom_range(0, 2) == 0);
      send(i, c, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    @(posedge clk);
    #1;
    valid_v[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] wv;
    int blen;
    for (int i = 0; i < 3; i++) begin
      valid_v[i] = 1'b0;
      code_v[i]  = 5'd0;
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_w", i, 64'(w_v[i]), 64'd0);
      check("reset_ready", i, 64'(rdy[i]), 64'd1);
      check("reset_busy", i, 64'(busy_v[i]), 64'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);

    // B at one clock per unit.
    send(0, 5'd1, 1'b0);
    capture(0, wv, blen);
    check("B_w_pattern", 0, {52'd0, wv[11:0]}, 64'b1110_1010_1000);
    check("B_busy_len", 0, 64'(blen), 64'd12);

    // E at four clocks per unit.
    send(2, 5'd4, 1'b0);
    capture(2, wv, blen);
    check("E_w_pattern", 2, {48'd0, wv[15:0]}, 64'hF000);
    check("E_busy_len", 2, 64'(blen), 64'd16);

    // E then T with valid held high.
    send(0, 5'd4, 1'b1);
    code_v[0] = 5'd19;
    capture(0, wv, blen);
    check("ET_E_w", 0, {60'd0, wv[3:0]}, 64'b1000);
    check("ET_E_busy_len", 0, 64'(blen), 64'd4);
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    capture(0, wv, blen);
    check("ET_T_w", 0, {58'd0, wv[5:0]}, 64'b111000);
    check("ET_T_busy_len", 0, 64'(blen), 64'd6);

    // Word space then an invalid code at two clocks per unit.
    send(1, 5'd26, 1'b0);
    capture(1, wv, blen);
    check("space_w", 1, wv, 64'd0);
    check("space_busy_len", 1, 64'(blen), 64'd14);
    send(1, 5'd30, 1'b0);
    capture(1, wv, blen);
    check("invalid_w", 1, wv, 64'd0);
    check("invalid_busy_len", 1, 64'(blen), 64'd1);

    // Reset in the middle of Q's first dash, valid held through reset.
    send(2, 5'd16, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("Q_mid_dash_w", 2, 64'(w_v[2]), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_w", 2, 64'(w_v[2]), 64'd0);
    check("abort_ready", 2, 64'(rdy[2]), 64'd1);
    valid_v[2] = 1'b1;
    code_v[2]  = 5'd0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 valid_v[2] = 1'b0;
    capture(2, wv, blen);
    check("A_after_reset_w", 2, {32'd0, wv[31:0]}, 64'hF0FF_F000);
    check("A_after_reset_busy_len", 2, 64'(blen), 64'd32);

    // Randomized traffic on all three keyers at once.
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    repeat (100) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Character-to-Morse keying stage that feeds the Morse letter detectors. It accepts one character code per handshake and drives the serial on/off keying line `w` with standard Morse timing: dot 1 unit, dash 3 units, inter-element space 1 unit, and letter gap 3 units. A word-space code produces 7 units low. One unit is `UNIT_CYCLES` clocks.

## Interface
- `UNIT_CYCLES`, default 4: clocks per Morse time unit; legal values are 1 and above.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `char_valid` input, 1 bit: upstream has a character on `char_code`.
- `char_code` input, 5 bits: 0–25 = A–Z, 26 = word space, 27–31 = invalid.
- `char_ready` output, 1 bit: block can accept a character. It is high exactly when the state is IDLE.
- `w` output, 1 bit: keying line, 1 = mark. Registered.
- `busy` output, 1 bit: a character is in progress. It is the inverse of `char_ready`.

## Operation
- Handshake: a character is accepted on a rising edge where `char_valid` and `char_ready` are both high. `char_code` is latched at that edge, and later changes are ignored until the next accept.
- Lookup per letter:
  - length `n`, from 1 to 4;
  - pattern, sent MSB-first, with 1 = dash and 0 = dot;
  - example: B has `n` = 4 and pattern 1000, i.e. dash, dot, dot, dot.
- FSM states: IDLE, MARK, SPACE, GAP.
- IDLE → MARK on accept of a code from 0 to 25. Element index = 0. Unit count = 3 if the element is a dash, else 1.
- MARK:
  - `w` = 1;
  - when the unit count expires: if the index is less than n−1, go to SPACE (1 unit); otherwise go to GAP (3 units).
- SPACE:
  - `w` = 0;
  - on expiry, increment the index and go to MARK with that element's unit count.
- GAP:
  - `w` = 0;
  - on expiry, go to IDLE.
- Code 26: IDLE → GAP with 7 units. `w` stays 0.
- Codes 27–31: accepted and dropped. The block goes IDLE → GAP with 0 units, so it returns to IDLE on the next edge (one cycle busy), and `w` stays 0.
- Counters:
  - cycle counter, `$clog2(UNIT_CYCLES)` bits, minimum 1 bit, wraps at `UNIT_CYCLES`−1;
  - unit counter, 3 bits, maximum value 7;
  - element index, 2 bits.
  - Counters never wrap past their terminal values; each state reloads them on entry.
- Reset values, applied immediately and asynchronously: state = IDLE, `w` = 0, `char_ready` = 1, `busy` = 0, all counters = 0.
- Reset mid-character aborts it: `w` falls at once, and no partial gap is emitted after reset is released.

## Timing
- The accept edge is k. Let T be the total units for the character:
  - letters: the sum of mark units, plus (n−1) spaces, plus 3 gap units;
  - word space: 7;
  - invalid code: 0.
- First mark: `w` = 1 starting at edge k+1 for letters.
- Return to IDLE: state = IDLE and `char_ready` = 1 from edge k+1+T·`UNIT_CYCLES` (invalid codes: edge k+1).
- Back-to-back characters: if `char_valid` is held high, the next accept happens at that IDLE edge. Characters are therefore separated by exactly the 3-unit gap plus one IDLE cycle.
- Every mark and space lasts an exact multiple of `UNIT_CYCLES` clocks, with no jitter.
- Simultaneous `char_valid` and `reset`: reset wins and nothing is accepted.

## Structure
- Shared package `morse_pkg` holds:
  - constants: `DOT_UNITS`=1, `DASH_UNITS`=3, `ELEM_GAP_UNITS`=1, `LETTER_GAP_UNITS`=3, `WORD_GAP_UNITS`=7;
  - the code values `CODE_SPACE`=26 and `CODE_MAX_LETTER`=25;
  - the FSM state encoding.
- Sub-module `morse_rom`: combinational lookup from the 5-bit code to {length[2:0], pattern[3:0]}, covering A–Z. It returns length 0 for codes 26–31.
- `morse_keyer` itself contains the FSM, the latched pattern/length registers, and the counters.

## Test plan
- Reset, then idle: `w` = 0 and `char_ready` = 1; with `char_valid` = 0 for 20 cycles, `w` stays 0 and `busy` stays 0.
- `UNIT_CYCLES`=1, code 1 (B) accepted at edge 0:
  - `w` high on cycles 1–3, 5, 7 and 9;
  - `w` low on cycles 4, 6, 8 and 10–12;
  - `char_ready` returns at edge 13.
- `UNIT_CYCLES`=4, code 4 (E):
  - `w` high for 4 cycles, then low for 12 cycles;
  - `char_ready` returns at edge 17. T = 4.
- Back-to-back E, T, with `char_valid` held high and `UNIT_CYCLES`=1:
  - E's mark is on cycle 1 and `char_ready` returns at edge 5;
  - T is accepted at edge 5, with its mark on cycles 6–8;
  - T's gap is cycles 9–11, and IDLE is reached at edge 12.
- Code 26 at `UNIT_CYCLES`=2: `w` stays 0 and `busy` stays high for 14 cycles. Then code 30: `busy` is high for 1 cycle and `w` stays 0.
- Reset asserted mid-dash of Q (code 16, pattern 1101): `w` drops asynchronously and `char_ready` = 1. After release, a new A (code 0) sends dot then dash normally, with no leftover Q elements.
